// File: rtl/pht_if.sv
// Lookup/update handshake bundle between the branch predictor pipeline and pht_controller.
// master = pipeline side, slave = controller side.
interface pht_if #(
   parameter int unsigned INDEX_W = 10
);
   logic               lk_valid;
   logic [INDEX_W-1:0] lk_index;
   logic               lk_ready;
   logic               rd_valid;
   logic [1:0]         rd_data;
   logic               up_valid;
   logic [INDEX_W-1:0] up_index;
   logic [1:0]         up_data;
   logic               up_ready;

   modport master (
      output lk_valid, lk_index, up_valid, up_index, up_data,
      input  lk_ready, rd_valid, rd_data, up_ready
   );

   modport slave (
      input  lk_valid, lk_index, up_valid, up_index, up_data,
      output lk_ready, rd_valid, rd_data, up_ready
   );
endinterface

// File: rtl/pht_controller.sv
// Single-port PHT SRAM sequencer: clear sweep, lookup reads, and a small update
// write FIFO with youngest-match read bypass, sharing one SRAM op per cycle.
module pht_controller #(
   parameter int unsigned INDEX_W  = 10,
   parameter int unsigned DEPTH    = 4,
   parameter logic [1:0]  INIT_VAL = 2'b00
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear_req,
   pht_if.slave               bus,
   output logic               busy,
   output logic               sram_en,
   output logic               sram_we,
   output logic [INDEX_W-1:0] sram_addr,
   output logic [1:0]         sram_wdata,
   input  logic [1:0]         sram_rdata
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   logic [0:0]         state_reg;
   logic [INDEX_W-1:0] sweep_ptr_reg;
   logic [PTR_W-1:0]   head_reg;
   logic [PTR_W-1:0]   tail_reg;
   logic [CNT_W-1:0]   count_reg;
   logic [INDEX_W-1:0] fifo_index_mem [DEPTH];
   logic [1:0]         fifo_data_mem  [DEPTH];

   logic               rd_valid_reg;
   logic               byp_hit_reg;
   logic [1:0]         byp_data_reg;

   logic               run;
   logic               grant_ok;
   logic               fifo_full;
   logic               fifo_empty;
   logic               lk_acc;
   logic               up_acc;
   logic               pop;

   logic [PTR_W-1:0]   slot_age [DEPTH];
   logic [DEPTH-1:0]   slot_hit;
   logic               byp_hit_next;
   logic [1:0]         byp_data_next;
   logic [PTR_W-1:0]   best_age;

   assign run        = (state_reg == ST_RUN);
   assign grant_ok   = run & ~clear_req;
   assign fifo_full  = (count_reg == CNT_W'(DEPTH));
   assign fifo_empty = (count_reg == '0);

   assign bus.lk_ready = grant_ok & ~fifo_full;
   assign bus.up_ready = grant_ok & ~fifo_full;
   assign lk_acc       = bus.lk_valid & bus.lk_ready;
   assign up_acc       = bus.up_valid & bus.up_ready;

   // A full FIFO outranks lookups; otherwise drain only in lookup-free slots.
   assign pop  = grant_ok & (fifo_full | (~bus.lk_valid & ~fifo_empty));
   assign busy = ~run;

   // Age 0 is the head (oldest); a slot is live when its age is below the count.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
         assign slot_age[gi] = PTR_W'(gi) - head_reg;
         assign slot_hit[gi] = ({1'b0, slot_age[gi]} < count_reg) &&
                               (fifo_index_mem[gi] == bus.lk_index);
      end
   endgenerate

   always_comb begin
      byp_hit_next  = 1'b0;
      byp_data_next = 2'b00;
      best_age      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (slot_hit[i] && (!byp_hit_next || slot_age[i] > best_age)) begin
            byp_hit_next  = 1'b1;
            byp_data_next = fifo_data_mem[i];
            best_age      = slot_age[i];
         end
      end
      // The update accepted alongside the lookup is younger than anything queued.
      if (up_acc && (bus.up_index == bus.lk_index)) begin
         byp_hit_next  = 1'b1;
         byp_data_next = bus.up_data;
      end
   end

   always_comb begin
      sram_en    = 1'b0;
      sram_we    = 1'b0;
      sram_addr  = '0;
      sram_wdata = 2'b00;
      if (rst_n) begin
         if (!run) begin
            sram_en    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = sweep_ptr_reg;
            sram_wdata = INIT_VAL;
         end else if (pop) begin
            sram_en    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = fifo_index_mem[head_reg];
            sram_wdata = fifo_data_mem[head_reg];
         end else if (lk_acc) begin
            sram_en    = 1'b1;
            sram_addr  = bus.lk_index;
         end
      end
   end

   assign bus.rd_valid = rd_valid_reg;
   assign bus.rd_data  = rd_valid_reg ? (byp_hit_reg ? byp_data_reg : sram_rdata) : 2'b00;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_CLEAR;
         sweep_ptr_reg <= '0;
         head_reg      <= '0;
         tail_reg      <= '0;
         count_reg     <= '0;
         rd_valid_reg  <= 1'b0;
         byp_hit_reg   <= 1'b0;
         byp_data_reg  <= 2'b00;
      end else begin
         rd_valid_reg <= lk_acc;
         byp_hit_reg  <= lk_acc & byp_hit_next;
         byp_data_reg <= byp_data_next;
         if (!run) begin
            sweep_ptr_reg <= clear_req ? '0 : sweep_ptr_reg + 1'b1;
            if (!clear_req && (sweep_ptr_reg == {INDEX_W{1'b1}})) begin
               state_reg <= ST_RUN;
            end
         end else if (clear_req) begin
            state_reg     <= ST_CLEAR;
            sweep_ptr_reg <= '0;
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
         end else begin
            if (up_acc) begin
               tail_reg <= tail_reg + 1'b1;
            end
            if (pop) begin
               head_reg <= head_reg + 1'b1;
            end
            count_reg <= count_reg + CNT_W'(up_acc) - CNT_W'(pop);
         end
      end
   end

   // Entry storage carries no reset; liveness comes from head/count alone.
   always_ff @(posedge clk) begin
      if (up_acc) begin
         fifo_index_mem[tail_reg] <= bus.up_index;
         fifo_data_mem[tail_reg]  <= bus.up_data;
      end
   end

endmodule

// File: tb/tb_pht_controller.sv
// Randomized bench for pht_controller: an SRAM model, a queue-based reference
// model checked on every falling edge, and a few hand-computed directed checks.
module tb_pht_controller;

   localparam int INDEX_W = 10;
   localparam int DEPTH   = 4;
   localparam int NENT    = 1 << INDEX_W;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               clear_req = 1'b0;
   logic               busy;
   logic               sram_en;
   logic               sram_we;
   logic [INDEX_W-1:0] sram_addr;
   logic [1:0]         sram_wdata;
   logic [1:0]         sram_rdata;

   pht_if #(.INDEX_W(INDEX_W)) bus ();

   pht_controller #(.INDEX_W(INDEX_W), .DEPTH(DEPTH), .INIT_VAL(2'b00)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_req  (clear_req),
      .bus        (bus),
      .busy       (busy),
      .sram_en    (sram_en),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata)
   );

   always #5 clk = ~clk;

   // SRAM macro model: synchronous write, read data valid the next cycle
   logic [1:0] mem [NENT];
   always @(posedge clk) begin
      if (sram_en) begin
         if (sram_we) mem[sram_addr] <= sram_wdata;
         else         sram_rdata     <= mem[sram_addr];
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state: mode, sweep pointer, pending updates, table contents
   bit m_clear = 1'b1;
   int m_ptr = 0;
   int q_idx[$];
   int q_dat[$];
   int m_tbl [NENT];
   bit m_rdv = 1'b0;
   int m_rdd = 0;

   always @(negedge clk) begin
      bit e_en, e_we, e_lkr, e_upr, lk_acc, up_acc, do_pop, found;
      int e_addr, e_wd, bval;
      if (!rst_n) begin
         chk("rst_busy", busy, 1);
         chk("rst_sram_en", sram_en, 0);
         chk("rst_sram_we", sram_we, 0);
         chk("rst_sram_addr", sram_addr, 0);
         chk("rst_sram_wdata", sram_wdata, 0);
         chk("rst_rd_valid", bus.rd_valid, 0);
         chk("rst_rd_data", bus.rd_data, 0);
         chk("rst_lk_ready", bus.lk_ready, 0);
         chk("rst_up_ready", bus.up_ready, 0);
         m_clear = 1'b1;
         m_ptr   = 0;
         q_idx.delete();
         q_dat.delete();
         m_rdv   = 1'b0;
      end else begin
         chk("rd_valid", bus.rd_valid, m_rdv);
         if (m_rdv) chk("rd_data", bus.rd_data, m_rdd);
         e_en = 0; e_we = 0; e_addr = 0; e_wd = 0; e_lkr = 0; e_upr = 0; do_pop = 0;
         if (m_clear) begin
            e_en = 1; e_we = 1; e_addr = m_ptr; e_wd = 0;
         end else if (!clear_req) begin
            e_lkr = (q_idx.size() < DEPTH);
            e_upr = e_lkr;
            if (q_idx.size() == DEPTH || (!bus.lk_valid && q_idx.size() > 0)) begin
               do_pop = 1; e_en = 1; e_we = 1; e_addr = q_idx[0]; e_wd = q_dat[0];
            end else if (bus.lk_valid) begin
               e_en = 1; e_addr = int'(bus.lk_index);
            end
         end
         chk("busy", busy, m_clear);
         chk("lk_ready", bus.lk_ready, e_lkr);
         chk("up_ready", bus.up_ready, e_upr);
         chk("sram_en", sram_en, e_en);
         if (e_en) begin
            chk("sram_we", sram_we, e_we);
            chk("sram_addr", sram_addr, e_addr);
            if (e_we) chk("sram_wdata", sram_wdata, e_wd);
         end
         lk_acc = bus.lk_valid && e_lkr;
         up_acc = bus.up_valid && e_upr;
         m_rdv  = lk_acc;
         if (lk_acc) begin
            found = 0; bval = 0;
            if (up_acc && bus.up_index == bus.lk_index) begin
               found = 1; bval = int'(bus.up_data);
            end
            for (int k = q_idx.size() - 1; k >= 0 && !found; k--) begin
               if (q_idx[k] == int'(bus.lk_index)) begin
                  found = 1; bval = q_dat[k];
               end
            end
            m_rdd = found ? bval : m_tbl[int'(bus.lk_index)];
         end
         if (m_clear) begin
            m_tbl[m_ptr] = 0;
            if (clear_req)            m_ptr = 0;
            else if (m_ptr == NENT-1) begin m_ptr = 0; m_clear = 0; end
            else                      m_ptr++;
         end else if (clear_req) begin
            m_clear = 1; m_ptr = 0;
            q_idx.delete(); q_dat.delete();
         end else begin
            if (do_pop) begin
               m_tbl[q_idx[0]] = q_dat[0];
               void'(q_idx.pop_front());
               void'(q_dat.pop_front());
            end
            if (up_acc) begin
               q_idx.push_back(int'(bus.up_index));
               q_dat.push_back(int'(bus.up_data));
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.lk_valid = 0; bus.lk_index = '0;
      bus.up_valid = 0; bus.up_index = '0; bus.up_data = 2'b00;
      clear_req = 0;
   endtask

   task automatic sweep_len_check(input string name);
      int n = 0;
      while (busy && n < 3000) begin
         cyc();
         n++;
      end
      chk(name, n, NENT);
   endtask

   task automatic random_traffic(input int ncyc, input int clr_mod);
      for (int c = 0; c < ncyc; c++) begin
         bus.lk_valid = ($urandom % 3) != 0;
         bus.lk_index = INDEX_W'($urandom % 8);
         bus.up_valid = $urandom % 2;
         bus.up_index = INDEX_W'($urandom % 8);
         bus.up_data  = 2'($urandom);
         clear_req    = (clr_mod > 0) && (($urandom % clr_mod) == 0);
         cyc();
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      repeat (3) cyc();
      rst_n = 1;
      #1;
      chk("first_sweep_addr", sram_addr, 0);
      chk("first_sweep_we", sram_we, 1);
      sweep_len_check("initial_sweep_len");
      chk("run_lk_ready", bus.lk_ready, 1);

      // update idx5 <- 11, then read it back through the SRAM
      bus.up_valid = 1; bus.up_index = 10'd5; bus.up_data = 2'b11;
      cyc();
      idle_inputs();
      #1;
      chk("upd5_we", sram_we, 1);
      chk("upd5_addr", sram_addr, 5);
      chk("upd5_wdata", sram_wdata, 3);
      cyc();
      bus.lk_valid = 1; bus.lk_index = 10'd5;
      cyc();
      idle_inputs();
      #1;
      chk("lk5_rd_valid", bus.rd_valid, 1);
      chk("lk5_rd_data", bus.rd_data, 3);
      cyc();
      #1;
      chk("lk5_pulse", bus.rd_valid, 0);

      // youngest queued entry wins while lookups keep the FIFO from draining
      bus.lk_valid = 1; bus.lk_index = 10'd7;
      bus.up_valid = 1; bus.up_index = 10'd7; bus.up_data = 2'b01;
      cyc();
      bus.up_data = 2'b10;
      cyc();
      bus.up_valid = 0;
      cyc();
      #1;
      chk("byp_youngest", bus.rd_data, 2);
      bus.up_valid = 1; bus.up_index = 10'd7; bus.up_data = 2'b11;
      cyc();
      idle_inputs();
      #1;
      chk("byp_same_cycle", bus.rd_data, 3);
      repeat (5) cyc();

      // back-pressure: four pushes under continuous lookups fill the FIFO
      bus.lk_valid = 1; bus.lk_index = 10'd9; bus.up_valid = 1;
      for (int k = 0; k < 4; k++) begin
         bus.up_index = INDEX_W'(20 + k); bus.up_data = 2'(k);
         cyc();
      end
      bus.up_valid = 0;
      #1;
      chk("full_lk_ready", bus.lk_ready, 0);
      chk("full_up_ready", bus.up_ready, 0);
      chk("full_head_addr", sram_addr, 20);
      cyc();
      #1;
      chk("after_full_lk_ready", bus.lk_ready, 1);
      idle_inputs();
      repeat (6) cyc();

      // clear with three queued updates: no SRAM op that cycle, sweep restarts
      bus.lk_valid = 1; bus.lk_index = 10'd1; bus.up_valid = 1;
      for (int k = 0; k < 3; k++) begin
         bus.up_index = INDEX_W'(30 + k); bus.up_data = 2'b11;
         cyc();
      end
      idle_inputs();
      clear_req = 1;
      #1;
      chk("clr_no_op", sram_en, 0);
      chk("clr_lk_ready", bus.lk_ready, 0);
      cyc();
      clear_req = 0;
      #1;
      chk("clr_sweep_addr0", sram_addr, 0);
      sweep_len_check("clear_sweep_len");

      random_traffic(4000, 900);
      begin
         int n = 0;
         while (busy && n < 3000) begin cyc(); n++; end
         chk("random_settle", busy, 0);
      end

      // reset mid-sweep at pointer 300
      clear_req = 1;
      cyc();
      clear_req = 0;
      repeat (300) cyc();
      chk("pre_rst_addr", sram_addr, 300);
      rst_n = 0;
      #1;
      chk("async_busy", busy, 1);
      chk("async_sram_en", sram_en, 0);
      chk("async_sram_addr", sram_addr, 0);
      chk("async_lk_ready", bus.lk_ready, 0);
      repeat (2) cyc();
      rst_n = 1;
      #1;
      chk("rerun_addr0", sram_addr, 0);
      chk("rerun_en", sram_en, 1);
      sweep_len_check("reset_sweep_len");

      random_traffic(500, 0);
      repeat (8) cyc();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
